// File: rtl/freq_meas_ctrl.sv
// Measurement sequencer for the zero-crossing frequency detector (adc_clk domain).
// Optional AUTO_REARM_EN: after a result handshake, re-arm straight into WAIT_STABLE.
module freq_meas_ctrl #(
    parameter int DATA_WIDTH     = 12,
    parameter int SETTLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int AVG_LOG2       = 2,
    parameter int SAMPLE_GAP     = 16,
    parameter int MAX_RETRY      = 2
) (
    input  logic                  adc_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] det_period,
    input  logic                  det_stable,
    output logic                  det_clear,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] result_period,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  err_timeout,
    output logic                  err_unstable,
    output logic [2:0]            retry_cnt,
    output logic [2:0]            state_dbg
);

    localparam int ACC_W       = DATA_WIDTH + AVG_LOG2;
    localparam int SMP_W       = AVG_LOG2 + 1;
    localparam int NUM_SAMPLES = 1 << AVG_LOG2;
    localparam int TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SET_W       = $clog2(SETTLE_CYCLES + 1);
    localparam int CNT_W       = (TMO_W > SET_W) ? TMO_W : SET_W;
    localparam int GAP_W       = $clog2(SAMPLE_GAP + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ONE     = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(SAMPLE_GAP - 1);
    localparam logic [SMP_W-1:0] SMP_ONE     = SMP_W'(1);
    localparam logic [SMP_W-1:0] SMP_LAST    = SMP_W'(NUM_SAMPLES - 1);
    localparam logic [2:0]       RETRY_MAX   = 3'(MAX_RETRY);

    // Valid/ready: result_valid rises with result_period already stable and
    // both hold until a cycle where result_valid && result_ready, which completes the transfer.
    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_CLEAR       = 3'd1,
        S_SETTLE      = 3'd2,
        S_WAIT_STABLE = 3'd3,
        S_ACCUM       = 3'd4,
        S_DONE        = 3'd5,
        S_ERROR       = 3'd6
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [GAP_W-1:0]   gap;
    logic [SMP_W-1:0]   smp_cnt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_sum;
    logic [ACC_W-1:0]   acc_avg;

    assign acc_sum   = acc + ACC_W'(det_period);
    assign acc_avg   = acc_sum >> AVG_LOG2;
    assign state_dbg = state;

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            gap           <= '0;
            smp_cnt       <= '0;
            acc           <= '0;
            det_clear     <= 1'b0;
            busy          <= 1'b0;
            result_period <= '0;
            result_valid  <= 1'b0;
            err_timeout   <= 1'b0;
            err_unstable  <= 1'b0;
            retry_cnt     <= 3'd0;
        end else if (abort && state != S_IDLE) begin
            // Abort leaves error flags, retry_cnt and the last result visible.
            state        <= S_IDLE;
            cnt          <= '0;
            gap          <= '0;
            det_clear    <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ERROR: begin
                    if (start && !abort) begin
                        err_timeout  <= 1'b0;
                        err_unstable <= 1'b0;
                        retry_cnt    <= 3'd0;
                        acc          <= '0;
                        smp_cnt      <= '0;
                        cnt          <= '0;
                        det_clear    <= 1'b1;
                        busy         <= 1'b1;
                        state        <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (cnt == CNT_ONE) begin
                        cnt       <= '0;
                        det_clear <= 1'b0;
                        state     <= S_SETTLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= S_WAIT_STABLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_WAIT_STABLE: begin
                    // Stable is tested first so it wins on the timeout cycle.
                    if (det_stable) begin
                        cnt     <= '0;
                        gap     <= '0;
                        smp_cnt <= '0;
                        acc     <= '0;
                        state   <= S_ACCUM;
                    end else if (cnt == TMO_LAST) begin
                        cnt         <= '0;
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_ERROR;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_ACCUM: begin
                    gap <= (gap == GAP_LAST) ? '0 : gap + GAP_ONE;
                    if (!det_stable) begin
                        if (retry_cnt < RETRY_MAX) begin
                            retry_cnt <= retry_cnt + 3'd1;
                            acc       <= '0;
                            smp_cnt   <= '0;
                            cnt       <= '0;
                            det_clear <= 1'b1;
                            state     <= S_CLEAR;
                        end else begin
                            err_unstable <= 1'b1;
                            busy         <= 1'b0;
                            state        <= S_ERROR;
                        end
                    end else if (gap == '0) begin
                        // A zero period means the detector glitched; restart the average.
                        if (det_period == '0) begin
                            acc     <= '0;
                            smp_cnt <= '0;
                        end else if (smp_cnt == SMP_LAST) begin
                            result_period <= acc_avg[DATA_WIDTH-1:0];
                            result_valid  <= 1'b1;
                            busy          <= 1'b0;
                            state         <= S_DONE;
                        end else begin
                            acc     <= acc_sum;
                            smp_cnt <= smp_cnt + SMP_ONE;
                        end
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
`ifdef AUTO_REARM_EN
                        retry_cnt    <= 3'd0;
                        cnt          <= '0;
                        busy         <= 1'b1;
                        state        <= S_WAIT_STABLE;
`else
                        state        <= S_IDLE;
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
